// File: rtl/aes_bus_sequencer_pkg.sv
// Shared definitions for the AES bus sequencer: core register map, control/status
// bit positions, sequencer states and small encoding helpers.
package aes_bus_sequencer_pkg;

    localparam logic [3:0] ADDR_IDLE   = 4'd0;
    localparam logic [3:0] ADDR_CONFIG = 4'd1;
    localparam logic [3:0] ADDR_KEY    = 4'd2;
    localparam logic [3:0] ADDR_BLOCK  = 4'd3;
    localparam logic [3:0] ADDR_STATUS = 4'd5;
    localparam logic [3:0] ADDR_START  = 4'd6;
    localparam logic [3:0] ADDR_RESULT = 4'd7;

    localparam int unsigned BIT_ENCDEC = 0;
    localparam int unsigned BIT_KEYLEN = 1;
    localparam int unsigned BIT_READY  = 0;
    localparam int unsigned BIT_VALID  = 1;
    localparam int unsigned BIT_INIT   = 0;
    localparam int unsigned BIT_NEXT   = 1;

    localparam logic [3:0] BLK_LAST_WORD = 4'd7;
    localparam logic [3:0] RES_LAST_BYTE = 4'd15;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CFG      = 4'd1,
        KEY_ADDR = 4'd2,
        KEY_DATA = 4'd3,
        INIT     = 4'd4,
        POLL_RDY = 4'd5,
        BLK_ADDR = 4'd6,
        BLK_DATA = 4'd7,
        NEXT     = 4'd8,
        POLL_VLD = 4'd9,
        RES_ADDR = 4'd10,
        RES_DATA = 4'd11,
        DONE     = 4'd12
    } seq_state_e;

    function automatic logic [15:0] cfg_word(input logic encdec, input logic keylen);
        logic [15:0] w;
        w             = 16'h0000;
        w[BIT_ENCDEC] = encdec;
        w[BIT_KEYLEN] = keylen;
        return w;
    endfunction

    function automatic logic [15:0] start_word(input int unsigned bit_idx);
        logic [15:0] w;
        w          = 16'h0000;
        w[bit_idx] = 1'b1;
        return w;
    endfunction

    // Index of the final key word: 8 words for a 128-bit key, 16 for 256-bit.
    function automatic logic [3:0] last_key_word(input logic keylen);
        return keylen ? 4'd15 : 4'd7;
    endfunction

endpackage

// File: rtl/aes_word_shifter.sv
// 256-bit shift register that presents key/block material one 16-bit word at a
// time, most significant word first.
module aes_word_shifter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [255:0] load_val,
    output logic [15:0]  word
);

    logic [255:0] sh_q;
    logic [255:0] sh_d;

    // Next value: a load wins over a shift.
    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_val;
        end else if (shift) begin
            sh_d = {sh_q[239:0], 16'h0000};
        end else begin
            sh_d = sh_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= 256'h0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign word = sh_q[255:240];

endmodule

// File: rtl/aes_bus_sequencer.sv
// Drives a register-mapped AES core through one command: configure, optionally
// load/expand the key, write the block, start, poll and read back the result.
module aes_bus_sequencer
    import aes_bus_sequencer_pkg::*;
#(
    parameter int POLL_LIMIT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_encdec,
    input  logic         cmd_keylen,
    input  logic         cmd_key_reload,
    input  logic [255:0] cmd_key,
    input  logic [127:0] cmd_block,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_err,
    output logic [127:0] rsp_data,
    output logic [3:0]   aes_address,
    output logic [15:0]  aes_data_in,
    input  logic [7:0]   aes_data_out
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
    localparam logic [PW-1:0] POLL_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] POLL_ONE  = PW'(1);

    seq_state_e     state_q, state_d;
    logic           encdec_q, encdec_d;
    logic           keylen_q, keylen_d;
    logic           reload_q, reload_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   block_q, block_d;
    logic           key_loaded_q, key_loaded_d;
    logic           loaded_keylen_q, loaded_keylen_d;
    logic [3:0]     word_cnt_q, word_cnt_d;
    logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [127:0]   rsp_data_q, rsp_data_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic [3:0]     addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;

    logic           sh_load_s;
    logic           sh_shift_s;
    logic [255:0]   sh_val_s;
    logic [15:0]    sh_word_s;
    logic [3:0]     byte_idx_s;

    assign byte_idx_s = RES_LAST_BYTE - word_cnt_q;

    aes_word_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load_s),
        .shift    (sh_shift_s),
        .load_val (sh_val_s),
        .word     (sh_word_s)
    );

    // Next-state, command capture, counters, response, then bus values for the next cycle.
    always_comb begin
        state_d         = state_q;
        encdec_d        = encdec_q;
        keylen_d        = keylen_q;
        reload_d        = reload_q;
        key_d           = key_q;
        block_d         = block_q;
        key_loaded_d    = key_loaded_q;
        loaded_keylen_d = loaded_keylen_q;
        word_cnt_d      = word_cnt_q;
        poll_cnt_d      = poll_cnt_q;
        rsp_err_d       = rsp_err_q;
        rsp_data_d      = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    encdec_d  = cmd_encdec;
                    keylen_d  = cmd_keylen;
                    reload_d  = cmd_key_reload;
                    key_d     = cmd_key;
                    block_d   = cmd_block;
                    rsp_err_d = 1'b0;
                    state_d   = CFG;
                end else begin
                    state_d = IDLE;
                end
            end
            CFG: begin
                if (reload_q || !key_loaded_q || (keylen_q != loaded_keylen_q)) begin
                    state_d = KEY_ADDR;
                end else begin
                    state_d = BLK_ADDR;
                end
            end
            KEY_ADDR: begin
                word_cnt_d = 4'd0;
                state_d    = KEY_DATA;
            end
            KEY_DATA: begin
                if (word_cnt_q == last_key_word(keylen_q)) begin
                    state_d = INIT;
                end else begin
                    word_cnt_d = word_cnt_q + 4'd1;
                end
            end
            INIT: begin
                poll_cnt_d = POLL_ZERO;
                state_d    = POLL_RDY;
            end
            POLL_RDY: begin
                if (aes_data_out[BIT_READY]) begin
                    key_loaded_d    = 1'b1;
                    loaded_keylen_d = keylen_q;
                    state_d         = BLK_ADDR;
                end else if (poll_cnt_q == POLL_LAST) begin
                    key_loaded_d = 1'b0;
                    rsp_err_d    = 1'b1;
                    state_d      = DONE;
                end else begin
                    poll_cnt_d = poll_cnt_q + POLL_ONE;
                end
            end
            BLK_ADDR: begin
                word_cnt_d = 4'd0;
                state_d    = BLK_DATA;
            end
            BLK_DATA: begin
                if (word_cnt_q == BLK_LAST_WORD) begin
                    state_d = NEXT;
                end else begin
                    word_cnt_d = word_cnt_q + 4'd1;
                end
            end
            NEXT: begin
                poll_cnt_d = POLL_ZERO;
                state_d    = POLL_VLD;
            end
            POLL_VLD: begin
                if (aes_data_out[BIT_VALID]) begin
                    state_d = RES_ADDR;
                end else if (poll_cnt_q == POLL_LAST) begin
                    key_loaded_d = 1'b0;
                    rsp_err_d    = 1'b1;
                    state_d      = DONE;
                end else begin
                    poll_cnt_d = poll_cnt_q + POLL_ONE;
                end
            end
            RES_ADDR: begin
                word_cnt_d = 4'd0;
                state_d    = RES_DATA;
            end
            RES_DATA: begin
                rsp_data_d[{byte_idx_s, 3'b000} +: 8] = aes_data_out;
                if (word_cnt_q == RES_LAST_BYTE) begin
                    state_d = DONE;
                end else begin
                    word_cnt_d = word_cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus outputs are registered, so they are decoded from the state being entered.
        addr_d     = ADDR_IDLE;
        wdata_d    = 16'h0000;
        sh_load_s  = 1'b0;
        sh_shift_s = 1'b0;
        sh_val_s   = 256'h0;
        case (state_d)
            CFG: begin
                addr_d  = ADDR_CONFIG;
                wdata_d = cfg_word(encdec_d, keylen_d);
            end
            KEY_ADDR: begin
                addr_d    = ADDR_KEY;
                sh_load_s = 1'b1;
                sh_val_s  = key_q;
            end
            KEY_DATA, BLK_DATA: begin
                addr_d     = ADDR_IDLE;
                wdata_d    = sh_word_s;
                sh_shift_s = 1'b1;
            end
            INIT: begin
                addr_d  = ADDR_START;
                wdata_d = start_word(BIT_INIT);
            end
            POLL_RDY, POLL_VLD: begin
                addr_d = ADDR_STATUS;
            end
            BLK_ADDR: begin
                addr_d    = ADDR_BLOCK;
                sh_load_s = 1'b1;
                sh_val_s  = {block_q, 128'h0};
            end
            NEXT: begin
                addr_d  = ADDR_START;
                wdata_d = start_word(BIT_NEXT);
            end
            RES_ADDR, RES_DATA: begin
                addr_d = ADDR_RESULT;
            end
            default: begin
                addr_d  = ADDR_IDLE;
                wdata_d = 16'h0000;
            end
        endcase

        rsp_valid_d = (state_d == DONE);
        cmd_ready_d = (state_d == IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            encdec_q        <= 1'b0;
            keylen_q        <= 1'b0;
            reload_q        <= 1'b0;
            key_q           <= 256'h0;
            block_q         <= 128'h0;
            key_loaded_q    <= 1'b0;
            loaded_keylen_q <= 1'b0;
            word_cnt_q      <= 4'd0;
            poll_cnt_q      <= POLL_ZERO;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            rsp_data_q      <= 128'h0;
            cmd_ready_q     <= 1'b1;
            addr_q          <= 4'd0;
            wdata_q         <= 16'h0000;
        end else begin
            state_q         <= state_d;
            encdec_q        <= encdec_d;
            keylen_q        <= keylen_d;
            reload_q        <= reload_d;
            key_q           <= key_d;
            block_q         <= block_d;
            key_loaded_q    <= key_loaded_d;
            loaded_keylen_q <= loaded_keylen_d;
            word_cnt_q      <= word_cnt_d;
            poll_cnt_q      <= poll_cnt_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_err_q       <= rsp_err_d;
            rsp_data_q      <= rsp_data_d;
            cmd_ready_q     <= cmd_ready_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_data    = rsp_data_q;
    assign aes_address = addr_q;
    assign aes_data_in = wdata_q;

endmodule

// File: tb/tb_aes_bus_sequencer.sv
// Bench for aes_bus_sequencer: a bus-level AES core stub with known-answer results,
// and a scoreboard of expected responses checked when each response is delivered.
module tb_aes_bus_sequencer;

    localparam int PL = 64;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K128X = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_encdec;
    logic         cmd_keylen;
    logic         cmd_key_reload;
    logic [255:0] cmd_key;
    logic [127:0] cmd_block;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_err;
    logic [127:0] rsp_data;
    logic [3:0]   aes_address;
    logic [15:0]  aes_data_in;
    logic [7:0]   aes_data_out;

    typedef struct packed {
        logic [127:0] data;
        logic         err;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    aes_bus_sequencer #(.POLL_LIMIT(PL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_encdec     (cmd_encdec),
        .cmd_keylen     (cmd_keylen),
        .cmd_key_reload (cmd_key_reload),
        .cmd_key        (cmd_key),
        .cmd_block      (cmd_block),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_err        (rsp_err),
        .rsp_data       (rsp_data),
        .aes_address    (aes_address),
        .aes_data_in    (aes_data_in),
        .aes_data_out   (aes_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AES core stub state
    logic         stub_stuck = 1'b0;
    int           stub_p = 0;
    int           stub_v = 0;
    logic [15:0]  stub_cfg = 16'h0000;
    logic [255:0] stub_key = 256'h0;
    logic [127:0] stub_blk = 128'h0;
    logic [255:0] stub_xkey = 256'h0;
    logic         stub_xlen = 1'b0;
    logic [127:0] stub_res = 128'h0;
    int           stub_mode = 0;
    int           stub_kcnt = 0;
    int           stub_bcnt = 0;
    logic         stub_rdy_armed = 1'b0;
    logic         stub_vld_armed = 1'b0;
    int           stub_rdy_left = 0;
    int           stub_vld_left = 0;
    int           stub_run = 0;
    int           n_key_cmd = 0;
    int           n_init = 0;

    function automatic logic [127:0] kat(input logic [255:0] k, input logic len,
                                         input logic [127:0] b, input logic enc);
        if (enc && len && k == K256 && b == PT) return CT256;
        if (enc && !len && k[255:128] == K128X[255:128] && b == PT) return CT128;
        if (!enc && !len && k[255:128] == K128X[255:128] && b == CT128) return PT;
        return b ^ k[255:128] ^ 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
    endfunction

    always @(posedge clk) begin
        stub_run <= (aes_address == 4'd7) ? stub_run + 1 : 0;
        if (aes_address == 4'd5 && stub_rdy_left > 0) stub_rdy_left <= stub_rdy_left - 1;
        if (aes_address == 4'd5 && stub_vld_left > 0) stub_vld_left <= stub_vld_left - 1;
        case (aes_address)
            4'd1: begin
                stub_cfg  <= aes_data_in;
                stub_mode <= 0;
            end
            4'd2: begin
                stub_mode <= 1;
                stub_kcnt <= 0;
                n_key_cmd <= n_key_cmd + 1;
            end
            4'd3: begin
                stub_mode <= 2;
                stub_bcnt <= 0;
            end
            4'd0: begin
                if (stub_mode == 1 && stub_kcnt < (stub_cfg[1] ? 16 : 8)) begin
                    stub_key[255-16*stub_kcnt -: 16] <= aes_data_in;
                    stub_kcnt <= stub_kcnt + 1;
                end else if (stub_mode == 2 && stub_bcnt < 8) begin
                    stub_blk[127-16*stub_bcnt -: 16] <= aes_data_in;
                    stub_bcnt <= stub_bcnt + 1;
                end
            end
            4'd6: begin
                if (aes_data_in == 16'h0001) begin
                    n_init         <= n_init + 1;
                    stub_xkey      <= stub_key;
                    stub_xlen      <= stub_cfg[1];
                    stub_rdy_armed <= 1'b1;
                    stub_rdy_left  <= stub_p;
                end else if (aes_data_in == 16'h0002) begin
                    stub_res       <= kat(stub_xkey, stub_xlen, stub_blk, stub_cfg[0]);
                    stub_vld_armed <= 1'b1;
                    stub_vld_left  <= stub_v;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        aes_data_out = 8'h00;
        if (!stub_stuck) begin
            if (aes_address == 4'd5) begin
                aes_data_out = {6'b000000, stub_vld_armed && stub_vld_left == 0,
                                stub_rdy_armed && stub_rdy_left == 0};
            end else if (aes_address == 4'd7 && stub_run >= 1 && stub_run <= 16) begin
                aes_data_out = stub_res[127-8*(stub_run-1) -: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic enc, input logic kl, input logic rl,
                           input logic [255:0] key, input logic [127:0] blk,
                           input int p, input int v, input int hold, input int exp_lat,
                           input logic exp_err, input logic [127:0] exp_data, input int exp_loads);
        int n;
        int k0;
        int i0;
        exp_t e;
        logic [127:0] snap;
        stub_p         = p;
        stub_v         = v;
        rsp_ready      = (hold == 0);
        cmd_encdec     = enc;
        cmd_keylen     = kl;
        cmd_key_reload = rl;
        cmd_key        = key;
        cmd_block      = blk;
        cmd_valid      = 1'b1;
        k0             = n_key_cmd;
        i0             = n_init;
        chk({tag, ".ready"}, 136'(cmd_ready), 136'd1);
        @(posedge clk); #1;
        e.data = exp_data;
        e.err  = exp_err;
        sb_q.push_back(e);
        n = 0;
        while (!rsp_valid && n < 200) begin
            cmd_valid      = (n < 10);
            cmd_encdec     = 1'($urandom);
            cmd_keylen     = 1'($urandom);
            cmd_key_reload = 1'($urandom);
            cmd_key        = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            cmd_block      = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0;
        chk({tag, ".latency"}, 136'(n), 136'(exp_lat));
        chk({tag, ".cfg"}, 136'(stub_cfg), 136'({kl, enc}));
        chk({tag, ".keyloads"}, 136'(n_key_cmd - k0), 136'(exp_loads));
        chk({tag, ".inits"}, 136'(n_init - i0), 136'(exp_loads));
        snap = rsp_data;
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            chk({tag, ".hold"}, {6'b000000, rsp_valid, cmd_ready, rsp_data}, {6'b000000, 1'b1, 1'b0, snap});
        end
        rsp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb"}, 136'd0, 136'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".valid"}, 136'(rsp_valid), 136'd1);
            chk({tag, ".data"}, 136'(rsp_data), 136'(e.data));
            chk({tag, ".err"}, 136'(rsp_err), 136'(e.err));
        end
        @(posedge clk); #1;
        chk({tag, ".idle"}, 136'({rsp_valid, cmd_ready}), 136'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_encdec     = 1'b0;
        cmd_keylen     = 1'b0;
        cmd_key_reload = 1'b0;
        cmd_key        = 256'h0;
        cmd_block      = 128'h0;
        rsp_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outs", {1'b0, cmd_ready, rsp_valid, rsp_err, aes_address, aes_data_in, rsp_data[111:0]},
            {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 112'h0});
        chk("reset.data", 136'(rsp_data), 136'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset.ready", 136'(cmd_ready), 136'd1);

        run_cmd("A256", 1'b1, 1'b1, 1'b1, K256,  PT,    3, 2, 0, 53, 1'b0, CT256, 1);
        run_cmd("B256", 1'b1, 1'b1, 1'b0, K256,  PT,    0, 4, 0, 33, 1'b0, CT256, 0);
        run_cmd("C128", 1'b1, 1'b0, 1'b0, K128X, PT,    0, 0, 0, 40, 1'b0, CT128, 1);
        run_cmd("Dhld", 1'b0, 1'b0, 1'b0, K128X, CT128, 0, 1, 5, 30, 1'b0, PT,    0);
        stub_stuck = 1'b1;
        run_cmd("Etmo", 1'b1, 1'b1, 1'b0, K256,  PT,    0, 0, 0, 19 + PL, 1'b1, PT, 1);
        stub_stuck = 1'b0;
        run_cmd("Frld", 1'b1, 1'b1, 1'b0, K256,  PT,    1, 1, 0, 50, 1'b0, CT256, 1);

        cmd_encdec     = 1'b1;
        cmd_keylen     = 1'b1;
        cmd_key_reload = 1'b1;
        cmd_key        = K256;
        cmd_block      = PT;
        cmd_valid      = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst.kd_addr", 136'(aes_address), 136'd0);
        chk("rst.kd_word", 136'(aes_data_in), 136'h0607);
        rst_n = 1'b0;
        #1;
        chk("rst.outs", {1'b0, cmd_ready, rsp_valid, rsp_err, aes_address, aes_data_in, rsp_data[111:0]},
            {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 112'h0});
        chk("rst.data", 136'(rsp_data), 136'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.noresp", 136'({rsp_valid, cmd_ready}), 136'd1);
        run_cmd("Gpost", 1'b1, 1'b1, 1'b0, K256, PT, 1, 1, 0, 50, 1'b0, CT256, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
